// File: rtl/wr_rx_streamer_deframer.sv
// WR streamer RX deframer: checks MAGIC/SEQ headers, rebuilds 32-bit words from 16-bit beats
// and buffers them with per-word frame flags in a show-ahead FIFO.
module wr_rx_streamer_deframer #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter logic [15:0] MAGIC      = 16'h5752
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [15:0] snk_data,
  input  logic        snk_valid,
  input  logic        snk_sof,
  input  logic        snk_eof,
  input  logic        snk_error,
  output logic        snk_stall,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_dreq,
  output logic        rx_first,
  output logic        rx_last,
  output logic        rx_lost,
  output logic        rx_error,
  output logic [31:0] cnt_frames,
  output logic [15:0] cnt_bad,
  output logic [15:0] cnt_lost
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] StallLevel = (AW + 1)'(FIFO_DEPTH - 2);

  typedef enum logic [2:0] {StIdle, StHdrSeq, StPayHi, StPayLo, StDiscard} state_e;

  state_e        state_q, state_d;
  logic [35:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [15:0]   hi_q, hi_d, expected_q, expected_d;
  logic [31:0]   pend_q, pend_d;
  logic          pend_valid_q, pend_valid_d;
  logic          lost_pend_q, lost_pend_d;
  logic          first_frame_q, first_frame_d;
  // set once the current frame has pushed a word; drives the first/lost flags
  logic          started_q, started_d;
  logic          accept, pop, eval_magic, frame_inc, lost_inc;
  logic [1:0]    n_push, bad_inc;
  logic [31:0]   s0_data, s1_data;
  logic          s0_last, s0_err;
  logic [35:0]   s0_entry, s1_entry, head;
  logic [16:0]   bad_sum;

  assign rx_valid  = (count_q != '0);
  assign snk_stall = (count_q >= StallLevel);
  assign accept    = snk_valid && !snk_stall;
  assign pop       = rx_valid && rx_dreq;

  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    expected_d    = expected_q;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    lost_pend_d   = lost_pend_q;
    first_frame_d = first_frame_q;
    eval_magic    = 1'b0;
    frame_inc     = 1'b0;
    lost_inc      = 1'b0;
    bad_inc       = 2'd0;
    n_push        = 2'd0;
    s0_data       = pend_q;
    s0_last       = 1'b0;
    s0_err        = 1'b0;
    s1_data       = {hi_q, snk_data};
    if (accept) begin
      unique case (state_q)
        StIdle:    eval_magic = snk_sof;
        StDiscard: if (snk_eof) state_d = StIdle;
        default: begin
          if (snk_error || snk_sof) begin
            // abort: flush the pending word as a truncated frame end
            if (pend_valid_q) begin
              s0_last = 1'b1;
              s0_err  = 1'b1;
              n_push  = 2'd1;
            end
            pend_valid_d = 1'b0;
            bad_inc      = 2'd1;
            if (snk_error) state_d = snk_eof ? StIdle : StDiscard;
            else           eval_magic = 1'b1;
          end else if (state_q == StHdrSeq) begin
            if (!first_frame_q && snk_data != expected_q) begin
              lost_pend_d = 1'b1;
              lost_inc    = 1'b1;
            end
            expected_d    = snk_data + 16'd1;
            first_frame_d = 1'b0;
            if (snk_eof) begin
              frame_inc = 1'b1;
              state_d   = StIdle;
            end else begin
              state_d = StPayHi;
            end
          end else if (state_q == StPayHi) begin
            hi_d = snk_data;
            if (snk_eof) begin
              if (pend_valid_q) begin
                s0_last = 1'b1;
                s0_err  = 1'b1;
                n_push  = 2'd1;
              end
              pend_valid_d = 1'b0;
              bad_inc      = 2'd1;
              state_d      = StIdle;
            end else begin
              state_d = StPayLo;
            end
          end else begin
            if (pend_valid_q) n_push = 2'd1;
            if (snk_eof) begin
              if (pend_valid_q) begin
                n_push = 2'd2;
              end else begin
                s0_data = {hi_q, snk_data};
                s0_last = 1'b1;
                n_push  = 2'd1;
              end
              pend_valid_d = 1'b0;
              frame_inc    = 1'b1;
              state_d      = StIdle;
            end else begin
              pend_d       = {hi_q, snk_data};
              pend_valid_d = 1'b1;
              state_d      = StPayHi;
            end
          end
        end
      endcase
    end
    started_d = started_q | (n_push != 2'd0);
    if (n_push != 2'd0 && !started_q) lost_pend_d = 1'b0;
    if (eval_magic) begin
      if (snk_data == MAGIC && !snk_eof) begin
        state_d   = StHdrSeq;
        started_d = 1'b0;
      end else begin
        bad_inc = bad_inc + 2'd1;
        state_d = snk_eof ? StIdle : StDiscard;
      end
    end
  end

  assign s0_entry = {s0_err, lost_pend_q & ~started_q, s0_last, ~started_q, s0_data};
  assign s1_entry = {1'b0, 1'b0, 1'b1, 1'b0, s1_data};
  assign bad_sum  = {1'b0, cnt_bad} + 17'(bad_inc);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      hi_q          <= '0;
      expected_q    <= '0;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
      lost_pend_q   <= 1'b0;
      first_frame_q <= 1'b1;
      started_q     <= 1'b0;
      cnt_frames    <= '0;
      cnt_bad       <= '0;
      cnt_lost      <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_q + AW'(n_push);
      rd_ptr_q      <= rd_ptr_q + AW'(pop);
      count_q       <= count_q + (AW + 1)'(n_push) - (AW + 1)'(pop);
      hi_q          <= hi_d;
      expected_q    <= expected_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      lost_pend_q   <= lost_pend_d;
      first_frame_q <= first_frame_d;
      started_q     <= started_d;
      cnt_frames    <= cnt_frames + 32'(frame_inc);
      cnt_bad       <= bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
      if (lost_inc && cnt_lost != 16'hFFFF) cnt_lost <= cnt_lost + 16'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (n_push != 2'd0) mem_q[wr_ptr_q] <= s0_entry;
    if (n_push == 2'd2) mem_q[wr_ptr_q + AW'(1)] <= s1_entry;
  end

  assign head = rx_valid ? mem_q[rd_ptr_q] : '0;
  assign {rx_error, rx_lost, rx_last, rx_first, rx_data} = head;

endmodule

// File: tb/tb_wr_rx_streamer_deframer.sv
// Self-checking bench: frame-level reference model feeds a word scoreboard; directed cases
// followed by randomized frames with random gaps and consumer backpressure.
module tb_wr_rx_streamer_deframer;
  localparam logic [15:0] MAGIC = 16'h5752;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [15:0] snk_data;
  logic        snk_valid, snk_sof, snk_eof, snk_error, snk_stall;
  logic [31:0] rx_data;
  logic        rx_valid, rx_dreq, rx_first, rx_last, rx_lost, rx_error;
  logic [31:0] cnt_frames;
  logic [15:0] cnt_bad, cnt_lost;

  always #5 clk_sys = ~clk_sys;

  wr_rx_streamer_deframer #(.FIFO_DEPTH(8), .MAGIC(MAGIC)) dut (
    .clk_sys(clk_sys), .rst(rst), .snk_data(snk_data), .snk_valid(snk_valid),
    .snk_sof(snk_sof), .snk_eof(snk_eof), .snk_error(snk_error), .snk_stall(snk_stall),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_dreq(rx_dreq), .rx_first(rx_first),
    .rx_last(rx_last), .rx_lost(rx_lost), .rx_error(rx_error), .cnt_frames(cnt_frames),
    .cnt_bad(cnt_bad), .cnt_lost(cnt_lost)
  );

  int          total, n_bad;
  logic [35:0] exp_q[$];
  logic [15:0] fr[$];
  int          dreq_mode;  // 0 hold off, 1 always ready, 2 random
  bit          gaps;

  logic [15:0] m_exp;
  bit          m_first, m_lost_pend;
  int unsigned m_frames;
  int          m_bad, m_lost;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    total++;
    assert (got === expv) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic model_reset();
    m_exp = 16'd0; m_first = 1'b1; m_lost_pend = 1'b0;
    m_frames = 0; m_bad = 0; m_lost = 0;
    exp_q.delete();
  endtask

  // Whole-frame view: n beats are meaningful, trunc marks an abort/error ending.
  task automatic model_frame(input int n, input bit trunc);
    int nw;
    bit tr;
    logic [15:0] seq;
    if (n < 2 || fr[0] != MAGIC) begin
      if (m_bad < 65535) m_bad++;
      return;
    end
    seq = fr[1];
    if (!m_first && seq != m_exp) begin
      m_lost_pend = 1'b1;
      if (m_lost < 65535) m_lost++;
    end
    m_exp = seq + 16'd1;
    m_first = 1'b0;
    nw = (n - 2) / 2;
    tr = trunc || ((n - 2) % 2 == 1);
    for (int w = 0; w < nw; w++)
      exp_q.push_back({tr && (w == nw - 1), m_lost_pend && (w == 0), w == nw - 1, w == 0,
                       fr[2 + 2 * w], fr[3 + 2 * w]});
    if (nw > 0) m_lost_pend = 1'b0;
    if (tr) begin
      if (m_bad < 65535) m_bad++;
    end else begin
      m_frames++;
    end
  endtask

  // Called at a falling edge; advances to the next falling edge.
  task automatic cycle(output bit acc);
    logic [35:0] e;
    case (dreq_mode)
      0:       rx_dreq = 1'b0;
      1:       rx_dreq = 1'b1;
      default: rx_dreq = ($urandom_range(0, 3) != 0);
    endcase
    if (rx_valid && rx_dreq) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {rx_error, rx_lost, rx_last, rx_first, rx_data}, 64'hX);
      end else begin
        e = exp_q.pop_front();
        check("word", {rx_error, rx_lost, rx_last, rx_first, rx_data}, e);
      end
    end
    acc = snk_valid && !snk_stall;
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic send_beat(input logic [15:0] d, input bit sof, input bit eof, input bit err);
    bit acc;
    acc = 1'b0;
    if (gaps && $urandom_range(0, 4) == 0) begin
      snk_valid = 1'b0;
      cycle(acc);
    end
    snk_valid = 1'b1; snk_data = d; snk_sof = sof; snk_eof = eof; snk_error = err;
    for (int t = 0; t < 200; t++) begin
      cycle(acc);
      if (acc) break;
    end
    if (!acc) check("beat_accept_timeout", 0, 1);
    snk_valid = 1'b0; snk_sof = 1'b0; snk_eof = 1'b0; snk_error = 1'b0;
  endtask

  task automatic send_frame(input int start, input bit abort, input int err_at);
    for (int i = start; i < fr.size(); i++)
      send_beat(fr[i], i == 0, (i == fr.size() - 1) && !abort, i == err_at);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cnt_frames"}, cnt_frames, m_frames);
    check({tag, "_cnt_bad"}, cnt_bad, m_bad[15:0]);
    check({tag, "_cnt_lost"}, cnt_lost, m_lost[15:0]);
  endtask

  task automatic run_frame(input bit abort, input int err_at, input string tag);
    if (err_at > 0) model_frame(err_at, 1'b1);
    else            model_frame(fr.size(), abort);
    send_frame(0, abort, err_at);
    if (!abort) check_counters(tag);
  endtask

  task automatic drain(input string tag);
    bit acc;
    int prev;
    prev = dreq_mode;
    dreq_mode = 1;
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) cycle(acc);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_empty"}, rx_valid, 0);
    dreq_mode = prev;
  endtask

  int          idx, kind, nh, ea;
  bit          ab, acc, stalled;
  logic [15:0] gen_seq;

  initial begin
    rst = 1'b1; snk_valid = 1'b0; snk_data = '0; snk_sof = 1'b0; snk_eof = 1'b0;
    snk_error = 1'b0; rx_dreq = 1'b0; dreq_mode = 1; gaps = 1'b0;
    model_reset();
    @(negedge clk_sys);
    @(negedge clk_sys);
    rst = 1'b0;
    check("rst_rx_valid", rx_valid, 0);
    check("rst_snk_stall", snk_stall, 0);
    check("rst_rx_data", {rx_error, rx_lost, rx_last, rx_first, rx_data}, 0);
    check_counters("rst");

    fr = '{MAGIC, 16'h0000, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    run_frame(1'b0, -1, "basic");
    drain("basic");
    check("basic_frames_const", cnt_frames, 1);

    fr = '{MAGIC, 16'h0001, 16'h0101, 16'h0202}; run_frame(1'b0, -1, "seq1");
    fr = '{MAGIC, 16'h0003, 16'h0303, 16'h0404}; run_frame(1'b0, -1, "seq3");
    check("gap_cnt_lost_const", cnt_lost, 1);
    fr = '{MAGIC, 16'hFFFF, 16'h0505, 16'h0606}; run_frame(1'b0, -1, "seqffff");
    fr = '{MAGIC, 16'h0000, 16'h0707, 16'h0808}; run_frame(1'b0, -1, "seqwrap");
    check("wrap_cnt_lost_const", cnt_lost, 2);

    fr = '{16'h1234, 16'h0001, 16'h0002}; run_frame(1'b0, -1, "badmagic");
    check("badmagic_cnt_bad_const", cnt_bad, 1);
    fr = '{MAGIC, 16'h0001, 16'h4444, 16'h5555}; run_frame(1'b0, -1, "good");
    fr = '{MAGIC, 16'h0005, 16'h1111, 16'h2222, 16'h3333}; run_frame(1'b0, -1, "odd");
    fr = '{MAGIC, 16'h0006, 16'h1111, 16'h2222, 16'h3333, 16'h4444}; run_frame(1'b1, -1, "abort");
    fr = '{MAGIC, 16'h0007, 16'h9999, 16'h8888}; run_frame(1'b0, -1, "after_abort");
    fr = '{MAGIC, 16'h0008, 16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4, 16'hE5E5, 16'hF6F6};
    run_frame(1'b0, 4, "snkerr");
    drain("directed");

    // 40-word frame against an 8-deep FIFO with the consumer held off.
    fr.delete();
    fr.push_back(MAGIC);
    fr.push_back(m_exp);
    for (int i = 0; i < 80; i++) fr.push_back(16'(i * 16'h0101 + 16'h1000));
    model_frame(fr.size(), 1'b0);
    dreq_mode = 0; idx = 0; stalled = 1'b0;
    for (int t = 0; t < 60 && !stalled; t++) begin
      snk_valid = 1'b1; snk_data = fr[idx]; snk_sof = (idx == 0);
      if (snk_stall) stalled = 1'b1;
      else begin
        cycle(acc);
        if (acc) idx++;
      end
    end
    check("stall_beats_before", idx, 16);
    for (int t = 0; t < 3; t++) begin
      cycle(acc);
      if (acc) idx++;
    end
    check("stall_held", snk_stall, 1);
    check("stall_no_accept", idx, 16);
    snk_valid = 1'b0; snk_sof = 1'b0;
    dreq_mode = 1;
    send_frame(idx, 1'b0, -1);
    check_counters("stall");
    drain("stall");

    // Reset in the middle of a frame with one word already queued.
    dreq_mode = 0;
    fr = '{MAGIC, 16'h0009, 16'h1212, 16'h3434, 16'h5656, 16'h7878};
    for (int i = 0; i < fr.size(); i++) send_beat(fr[i], i == 0, 1'b0, 1'b0);
    check("pre_rst_valid", rx_valid, 1);
    rst = 1'b1;
    cycle(acc);
    rst = 1'b0;
    model_reset();
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_stall", snk_stall, 0);
    check_counters("midrst");
    dreq_mode = 1;
    fr = '{MAGIC, 16'h0000}; run_frame(1'b0, -1, "empty0");
    fr = '{MAGIC, 16'h0002}; run_frame(1'b0, -1, "empty2");
    fr = '{MAGIC, 16'h0003, 16'hCAFE, 16'hF00D}; run_frame(1'b0, -1, "after_empty");
    check("empty_gap_lost_const", cnt_lost, 1);
    drain("empty");

    gaps = 1'b1; dreq_mode = 2; gen_seq = m_exp;
    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 9);
      fr.delete(); ab = 1'b0; ea = -1;
      if (kind == 0) begin
        fr.push_back({1'b1, 15'($urandom)});
        nh = $urandom_range(0, 3);
        for (int i = 0; i < nh; i++) fr.push_back(16'($urandom));
      end else begin
        fr.push_back(MAGIC);
        if ($urandom_range(0, 5) == 0) gen_seq = gen_seq + 16'($urandom_range(1, 5));
        fr.push_back(gen_seq);
        gen_seq = gen_seq + 16'd1;
        nh = $urandom_range(0, 9);
        for (int i = 0; i < nh; i++) fr.push_back(16'($urandom));
        if (kind == 1 && f < 59) ab = 1'b1;
        else if (kind == 2) ea = $urandom_range(1, fr.size() - 1);
      end
      run_frame(ab, ea, "rand");
    end
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, n_bad);
    $finish;
  end

endmodule

// File: doc/wr_rx_streamer_deframer.md
# wr_rx_streamer_deframer

Receive-side deframer for the WR streamer link: consumes 16-bit fabric beats of streamer frames, validates the header, reassembles 32-bit payload words, and delivers them on the `rx_data`/`rx_valid`/`rx_dreq`/`rx_last` word interface. It is the counterpart of the TX streamer framer. It also reports sequence gaps and malformed frames. An internal FIFO decouples fabric arrival from the consumer's `rx_dreq` backpressure.

## Interface
- `FIFO_DEPTH`, 64: output FIFO entries; power of two, minimum 8.
- `MAGIC`, 16'h5752: required first beat of every frame.
- `clk_sys`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `snk_data`  in  16  fabric beat.
- `snk_valid`  in  1  beat present.
- `snk_sof`  in  1  first beat of frame.
- `snk_eof`  in  1  last beat of frame.
- `snk_error`  in  1  fabric error on this beat.
- `snk_stall`  out  1  backpressure. A beat is accepted when `snk_valid && !snk_stall`.
- `rx_data`  out  32  payload word; show-ahead.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_dreq`  in  1  consumer ready. Transfer when `rx_valid && rx_dreq`.
- `rx_first`  out  1  word is first of its frame.
- `rx_last`  out  1  word is last of its frame.
- `rx_lost`  out  1  sequence gap precedes this word's frame.
- `rx_error`  out  1  frame truncated or corrupted; word is valid data, and the frame is incomplete.
- `cnt_frames`  out  32  good frames received; wraps.
- `cnt_bad`  out  16  discarded or errored frames; saturates at 0xFFFF.
- `cnt_lost`  out  16  sequence-gap events; saturates at 0xFFFF.

## Operation
- **Frame format:** `MAGIC`, then `SEQ` (16-bit), then payload halves, high half first; `snk_eof` is on the final beat.
- **FIFO entry:** 36 bits, `{error, lost, last, first, data}`.
- **States:**
  - IDLE
    - Beats without `sof` are ignored.
    - `sof` with `data==MAGIC` and no `eof` goes to HDR_SEQ.
    - Any other `sof` beat goes to DISCARD (IDLE if `eof`) and increments `cnt_bad`.
  - HDR_SEQ
    - Compare `SEQ` with `expected`. On mismatch, and not the first frame since reset: set `lost_pend` and increment `cnt_lost`.
    - Set `expected = SEQ+1` (mod 2^16) and clear the first-frame flag.
    - With `eof`: empty frame. Return to IDLE, increment `cnt_frames`, push nothing; `lost_pend` carries to the next frame.
    - Otherwise go to PAY_HI.
  - PAY_HI
    - Latch the high half and go to PAY_LO.
    - `eof` here means an odd half count: drop the half. If a pending word exists, push it with `last=1, error=1`. Increment `cnt_bad`, go to IDLE.
  - PAY_LO
    - Assemble `{hi, lo}`. Any existing pending word is pushed with `last=0`, then the new word becomes pending.
    - With `eof`: push the new word directly with `last=1`, increment `cnt_frames`, go to IDLE.
    - Otherwise go to PAY_HI.
  - DISCARD: drop beats until `eof`, then go to IDLE.
- **Word flags:** `first` is set on the first pushed word of a frame. `lost` equals `lost_pend` on that first word; `lost_pend` is cleared at that push.
- **Mid-frame `sof`:** the current frame is aborted (pending word pushed with `last=1, error=1`, `cnt_bad`++). The beat is then evaluated as a new frame's MAGIC.
- **`snk_error` on an accepted beat in HDR_SEQ/PAY_*:** handled as an abort, same as mid-frame `sof`. Go to DISCARD, or to IDLE if `eof`.
- **`snk_stall`:** 1 when FIFO free entries < 3, computed from the registered count. The FIFO never overflows.
- **Reset:**
  - State is IDLE; FIFO and pending register are emptied.
  - `lost_pend=0`; first-frame flag set; `expected=0`.
  - All counters are 0. `rx_valid=0`, `snk_stall=0`.
  - `rx_data`/flags are 0 while empty.
  - Reset mid-frame discards everything, including FIFO contents.

## Timing
- **Push:** happens at the clock edge that accepts the completing beat. `rx_valid` is high in the following cycle (one-cycle push-to-visible).
- **Latency:**
  - The last word of a frame is visible one cycle after its `eof` beat is accepted.
  - Non-last words are visible one cycle after the next low half (or `eof`) is accepted.
- **Pop:** a transfer at edge N presents the next entry from cycle N+1. Full-rate pop is allowed (one word per cycle).
- **Simultaneous push and pop** in the same cycle is allowed at any occupancy; the count is unchanged.
- **Counters** update at the edge accepting the deciding beat.
- **No bubbles required:** the block sustains one beat per cycle on input while `snk_stall=0`.

## Test plan
- Frame `5752, 0000, AAAA, BBBB, CCCC, DDDD(eof)`, `rx_dreq=1` -> words `AAAABBBB` (`first`) and `CCCCDDDD` (`last`); `cnt_frames=1`, `rx_lost=0`.
- Frames with `SEQ` 0, 1, then 3 -> third frame's first word has `rx_lost=1`, `cnt_lost=1`. `SEQ` FFFF then 0000 -> no loss (wrap).
- Bad magic `1234`, then a good frame -> `cnt_bad=1`, only good-frame words delivered. Odd payload `5752, 0005, 1111, 2222, 3333(eof)` -> `11112222` with `last=1, error=1`, `cnt_bad`++.
- `rx_dreq=0` while streaming 40 words with `FIFO_DEPTH=8` -> `snk_stall` asserts at 6 entries; after releasing `rx_dreq`, all 40 words arrive in order with none lost.
- Empty frame with a gap (`SEQ` 0, then `SEQ` 2 with no payload), then `SEQ` 3 with payload -> `SEQ` 3's first word has `rx_lost=1`. `rst` pulsed mid-frame -> `rx_valid=0` next cycle, counters 0, and the next frame is accepted cleanly.
